// File: rtl/arb_pkg.sv
// Shared constants and helpers for the arbiter tree (arbiter4, arb_out_fifo, tree top).
package arb_pkg;

    localparam int ARB_DW         = 8;
    localparam int ARB_FIFO_DEPTH = 4;

    // Ceiling log2; returns 0 for values <= 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/arb_fifo_mem.sv
// Purpose: DEPTH x DW register array, sync write / async read, no reset.
// Latency: write visible on rdata the cycle after the write edge.
// Backpressure: none; the owner gates we_i.
module arb_fifo_mem
    import arb_pkg::*;
#(
    parameter int DW    = ARB_DW,
    parameter int DEPTH = ARB_FIFO_DEPTH,
    parameter int AW    = clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/arb_out_fifo.sv
// Purpose: valid/ready FIFO absorbing the merged output stream of an arbiter4 stage.
// Latency: 1 cycle push-to-valid_out, no write-through.
// Backpressure: ready_out drops only when full (or in reset); status decoded from count register only.
module arb_out_fifo
    import arb_pkg::*;
#(
    parameter int DW       = ARB_DW,
    parameter int DEPTH    = ARB_FIFO_DEPTH,
    parameter int AF_LEVEL = DEPTH - 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       valid_in,
    input  logic [DW-1:0]              data_in,
    output logic                       ready_out,
    output logic                       valid_out,
    output logic [DW-1:0]              data_out,
    input  logic                       ready_in,
    output logic [clog2(DEPTH+1)-1:0]  count,
    output logic                       almost_full
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = clog2(DEPTH + 1);

    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT    = CW'(AF_LEVEL);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          push;
    logic          pop;
    logic [DW-1:0] head_dat;

    assign push = valid_in & ready_out;
    assign pop  = valid_out & ready_in;

    // Pointers are power-of-two wide, so the increment wraps DEPTH-1 -> 0 by itself.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    arb_fifo_mem #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (data_in),
        .raddr_i (rd_ptr_q),
        .rdata_o (head_dat)
    );

    // Gating with rst_n keeps the upstream arbiter from granting into a FIFO being cleared.
    assign ready_out   = (count_q != DEPTH_CNT) & rst_n;
    assign valid_out   = (count_q != '0);
    assign almost_full = (count_q >= AF_CNT);
    assign data_out    = valid_out ? head_dat : '0;
    assign count       = count_q;

endmodule

// File: tb/tb_arb_out_fifo.sv
`timescale 1ns/1ps
module tb_arb_out_fifo;

    logic       clk;
    logic       rst_n;
    logic       valid_in;
    logic [7:0] data_in;
    logic       ready_out;
    logic       valid_out;
    logic [7:0] data_out;
    logic       ready_in;
    logic [2:0] count;
    logic       almost_full;

    int n_cmp;
    int n_bad;
    int n_pop;

    logic [7:0] sb[$];
    logic       prev_stall;
    logic [7:0] prev_dat;

    arb_out_fifo #(.DW(8), .DEPTH(4), .AF_LEVEL(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .valid_in    (valid_in),
        .data_in     (data_in),
        .ready_out   (ready_out),
        .valid_out   (valid_out),
        .data_out    (data_out),
        .ready_in    (ready_in),
        .count       (count),
        .almost_full (almost_full)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp = n_cmp + 1;
        if (act != exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected-word producer: every accepted push becomes an expected output.
    always @(negedge clk) begin
        if (rst_n && valid_in && ready_out) begin
            sb.push_back(data_in);
        end
    end

    // Output monitor: order check on every pop, hold check after every stall.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_vld", int'(valid_out), 1);
                check("hold_dat", int'(data_out), int'(prev_dat));
            end
            if (valid_out && ready_in) begin
                if (sb.size() == 0) begin
                    n_cmp = n_cmp + 1;
                    n_bad = n_bad + 1;
                    $display("FAIL sb_underflow: got 0x%0h, expected no word at %0t", data_out, $time);
                end else begin
                    check("order", int'(data_out), int'(sb.pop_front()));
                end
                n_pop = n_pop + 1;
            end
            prev_stall = valid_out && !ready_in;
            prev_dat   = data_out;
        end
    end

    initial begin
        #(100 * 2000);
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] words [4];
        bit         rdy_pat [6];
        int         idx;
        int         cyc;
        int         pops0;
        bit         accept;

        words   = '{8'h21, 8'h43, 8'h65, 8'h87};
        rdy_pat = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        n_cmp = 0; n_bad = 0; n_pop = 0;
        prev_stall = 1'b0; prev_dat = '0;
        rst_n = 1'b0; valid_in = 1'b1; data_in = 8'hEE; ready_in = 1'b0;

        // Reset held two cycles with valid_in asserted.
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_ready", int'(ready_out), 0);
            check("rst_valid", int'(valid_out), 0);
            check("rst_count", int'(count), 0);
            check("rst_af", int'(almost_full), 0);
            check("rst_data", int'(data_out), 0);
        end
        rst_n = 1'b1; valid_in = 1'b0;
        tick();
        check("post_rst_count", int'(count), 0);
        check("post_rst_ready", int'(ready_out), 1);

        // Fill with consumer stalled.
        for (int i = 0; i < 4; i++) begin
            valid_in = 1'b1; data_in = words[i];
            tick();
            check("fill_count", int'(count), i + 1);
            check("fill_af", int'(almost_full), (i >= 2) ? 1 : 0);
            check("fill_ready", int'(ready_out), (i == 3) ? 0 : 1);
        end
        data_in = 8'h99;
        tick();
        check("full_count", int'(count), 4);
        check("full_head", int'(data_out), 8'h21);

        // Drain; ready_in=1 must not open ready_out while full.
        ready_in = 1'b1;
        #1;
        check("full_ready_in1", int'(ready_out), 0);
        tick();
        check("drain_count0", int'(count), 3);
        check("drain_ready", int'(ready_out), 1);
        tick();
        check("drain_count1", int'(count), 3);
        valid_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("drain_count", int'(count), 2 - i);
        end
        check("drain_valid", int'(valid_out), 0);
        check("drain_data", int'(data_out), 0);

        // Streaming across pointer wrap.
        ready_in = 1'b1; valid_in = 1'b1;
        for (int i = 0; i < 12; i++) begin
            data_in = 8'hA0 + 8'(i);
            tick();
            check("stream_count", int'(count), 1);
        end
        valid_in = 1'b0;
        tick();
        check("stream_end_count", int'(count), 0);

        // Backpressure toggle behind a four-lane arbiter stream.
        idx = 0; cyc = 0; pops0 = n_pop;
        while ((idx < 8 || sb.size() != 0) && cyc < 100) begin
            valid_in = (idx < 8);
            data_in  = words[idx % 4];
            ready_in = rdy_pat[cyc % 6];
            accept   = valid_in && ready_out;
            tick();
            if (accept) idx = idx + 1;
            cyc = cyc + 1;
        end
        valid_in = 1'b0;
        check("bp_done", (cyc < 100) ? 1 : 0, 1);
        check("bp_pops", n_pop - pops0, 8);

        // Mid-operation reset with three words queued.
        ready_in = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            valid_in = 1'b1; data_in = 8'h11 * 8'(i + 1);
            tick();
        end
        check("mid_count3", int'(count), 3);
        data_in = 8'h44; ready_in = 1'b1; rst_n = 1'b0;
        tick();
        check("mid_rst_count", int'(count), 0);
        check("mid_rst_valid", int'(valid_out), 0);
        rst_n = 1'b1; data_in = 8'h5A; ready_in = 1'b0;
        tick();
        valid_in = 1'b0;
        check("mid_first_count", int'(count), 1);
        check("mid_first_data", int'(data_out), 8'h5A);
        ready_in = 1'b1;
        tick();
        check("mid_end_count", int'(count), 0);
        check("sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
